// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch port, data port and unified memory port.
// The slave modport is the arbiter's view; master is the core/memory environment.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic              busy;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_ready,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output busy
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_ready,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory between the fetch and data ports, data first.
// Define ARB_STARVE_GUARD_EN to let fetch win after STARVE_LIMIT back-to-back data grants.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_I = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic              grant_d;
  logic              grant_i;
  logic              starve_force;

  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              if_ready_q;
  logic              d_ready_q;

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;

  assign starve_force = (starve_cnt == CNT_MAX) && bus.if_req && bus.d_req;

  // Counts data grants that left a fetch waiting; any relief for fetch clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!bus.if_req || grant_i) begin
        starve_cnt <= '0;
      end else if (grant_d && (starve_cnt != CNT_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`else
  assign starve_force = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.d_req && !starve_force) begin
          grant_d   = 1'b1;
          state_nxt = GNT_D;
        end else if (bus.if_req) begin
          grant_i   = 1'b1;
          state_nxt = GNT_I;
        end
      end
      GNT_D, GNT_I: begin
        if (bus.mem_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured at grant time so they stay frozen until the ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      if (grant_d) begin
        mem_we_q    <= bus.d_we;
        mem_addr_q  <= bus.d_addr;
        mem_wdata_q <= bus.d_wdata;
      end else if (grant_i) begin
        mem_we_q   <= 1'b0;
        mem_addr_q <= bus.if_addr;
      end
      if ((state == GNT_D) && bus.mem_ack) begin
        d_rdata_q <= bus.mem_rdata;
        d_ready_q <= 1'b1;
      end
      if ((state == GNT_I) && bus.mem_ack) begin
        if_rdata_q <= bus.mem_rdata;
        if_ready_q <= 1'b1;
      end
    end
  end

  assign bus.mem_req   = (state != IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ready   = d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays the memory and a scoreboard
// matches every ready pulse against the completion the bench itself issued.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          isData;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t popped;

  int checks      = 0;
  int errors      = 0;
  int pushes      = 0;
  int readyPulses = 0;
  int grants      = 0;
  int waited;

  logic        prevReq   = 1'b0;
  logic        prevWe    = 1'b0;
  logic [31:0] prevAddr  = '0;
  logic [31:0] prevWdata = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                               input logic dReq, input logic dWe,
                               input logic [31:0] dAddr, input logic [31:0] dWdata);
    bus.if_req  = ifReq;
    bus.if_addr = ifAddr;
    bus.d_req   = dReq;
    bus.d_we    = dWe;
    bus.d_addr  = dAddr;
    bus.d_wdata = dWdata;
  endtask

  // Plays the memory for one transaction; returns at the negedge where ready is visible.
  task automatic serveMem(input string tag, input bit expData, input logic expWe,
                          input logic [31:0] expAddr, input logic [31:0] expWdata,
                          input logic [31:0] rdata, input int ackDelay, output int nWait);
    nWait = 0;
    do begin
      @(negedge clk);
      nWait++;
    end while (!bus.mem_req && nWait < 20);
    if (!bus.mem_req) begin
      checkOutput({tag, "_timeout"}, bus.mem_req, 1);
      return;
    end
    checkOutput({tag, "_we"}, bus.mem_we, expWe);
    checkOutput({tag, "_addr"}, bus.mem_addr, expAddr);
    if (expWe) checkOutput({tag, "_wdata"}, bus.mem_wdata, expWdata);
    checkOutput({tag, "_busy"}, bus.busy, 1);
    repeat (ackDelay - 1) @(negedge clk);
    sb.push_back('{expData, rdata});
    pushes++;
    bus.mem_rdata = rdata;
    bus.mem_ack   = 1'b1;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = $urandom;
    checkOutput({tag, "_ready"}, expData ? bus.d_ready : bus.if_ready, 1);
    checkOutput({tag, "_other_ready"}, expData ? bus.if_ready : bus.d_ready, 0);
    checkOutput({tag, "_req_drop"}, bus.mem_req, 0);
  endtask

  // Scoreboard pop on every ready pulse plus request-hold and grant bookkeeping.
  always @(negedge clk) begin
    if (bus.if_ready || bus.d_ready) begin
      readyPulses++;
      checkOutput("sb_onehot", bus.if_ready & bus.d_ready, 0);
      if (sb.size() == 0) begin
        checkOutput("sb_underflow", sb.size(), 1);
      end else begin
        popped = sb.pop_front();
        checkOutput("sb_port", bus.d_ready, popped.isData);
        checkOutput("sb_rdata", popped.isData ? bus.d_rdata : bus.if_rdata, popped.rdata);
      end
    end
    if (bus.mem_req && !prevReq) grants++;
    if (bus.mem_req && prevReq) begin
      checkOutput("hold_we", bus.mem_we, prevWe);
      checkOutput("hold_addr", bus.mem_addr, prevAddr);
      checkOutput("hold_wdata", bus.mem_wdata, prevWdata);
    end
    prevReq   = bus.mem_req;
    prevWe    = bus.mem_we;
    prevAddr  = bus.mem_addr;
    prevWdata = bus.mem_wdata;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          expData;
    bit          isData;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;

    reset         = 1'b1;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);

    checkOutput("rst_mem_req", bus.mem_req, 0);
    checkOutput("rst_mem_we", bus.mem_we, 0);
    checkOutput("rst_mem_addr", bus.mem_addr, 0);
    checkOutput("rst_mem_wdata", bus.mem_wdata, 0);
    checkOutput("rst_if_ready", bus.if_ready, 0);
    checkOutput("rst_d_ready", bus.d_ready, 0);
    checkOutput("rst_if_rdata", bus.if_rdata, 0);
    checkOutput("rst_d_rdata", bus.d_rdata, 0);
    checkOutput("rst_busy", bus.busy, 0);
    reset = 1'b0;
    @(negedge clk);

    // Fetch only, ack two cycles into the request.
    applyStimulus(1, 32'h100, 0, 0, 0, 0);
    serveMem("t1", 0, 0, 32'h100, 0, 32'h00500093, 2, waited);
    bus.if_req = 1'b0;
    checkOutput("t1_rdata", bus.if_rdata, 32'h00500093);
    @(negedge clk);
    checkOutput("t1_single_pulse", bus.if_ready, 0);
    checkOutput("t1_rdata_hold", bus.if_rdata, 32'h00500093);

    // Collision: the store wins, fetch follows after one idle cycle.
    applyStimulus(1, 32'h200, 1, 1, 32'h2000, 32'hDEADBEEF);
    serveMem("t2d", 1, 1, 32'h2000, 32'hDEADBEEF, 32'h11111111, 1, waited);
    bus.d_req = 1'b0;
    checkOutput("t2_idle_busy", bus.busy, 0);
    serveMem("t2i", 0, 0, 32'h200, 0, 32'h22222222, 3, waited);
    checkOutput("t2_gap", waited, 1);
    bus.if_req = 1'b0;
    checkOutput("t2_store_rdata", bus.d_rdata, 32'h11111111);
    @(negedge clk);

    // Load at minimum latency.
    applyStimulus(0, 0, 1, 0, 32'h3000, 0);
    serveMem("t3", 1, 0, 32'h3000, 0, 32'hCAFEF00D, 1, waited);
    checkOutput("t3_latency", waited, 1);
    bus.d_req = 1'b0;
    checkOutput("t3_rdata", bus.d_rdata, 32'hCAFEF00D);
    @(negedge clk);

    // Reset during a fetch grant, then a stray ack in IDLE.
    applyStimulus(1, 32'h300, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t4_granted", bus.mem_req, 1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t4_req_drop", bus.mem_req, 0);
    checkOutput("t4_busy", bus.busy, 0);
    checkOutput("t4_no_ready", bus.if_ready, 0);
    checkOutput("t4_rdata_cleared", bus.if_rdata, 0);
    reset         = 1'b0;
    bus.if_req    = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    checkOutput("t4_stray_if_ready", bus.if_ready, 0);
    checkOutput("t4_stray_d_ready", bus.d_ready, 0);
    checkOutput("t4_stray_busy", bus.busy, 0);
    @(negedge clk);
    checkOutput("t4_stray_if_ready2", bus.if_ready, 0);
    checkOutput("t4_stray_if_rdata", bus.if_rdata, 0);
    checkOutput("t4_stray_d_rdata", bus.d_rdata, 0);

    // Data held high with a fetch pending.
    applyStimulus(1, 32'h500, 1, 0, 32'h4000, 0);
    for (int i = 0; i < 6; i++) begin
`ifdef ARB_STARVE_GUARD_EN
      expData = (i != 4);
`else
      expData = 1'b1;
`endif
      if (expData) begin
        serveMem("t5d", 1, 0, 32'h4000 + 32'(i * 4), 0, 32'h50000000 + 32'(i), 1, waited);
      end else begin
        serveMem("t5i", 0, 0, 32'h500, 0, 32'h50000000 + 32'(i), 1, waited);
        bus.if_req = 1'b0;
      end
      bus.d_addr = 32'h4000 + 32'((i + 1) * 4);
      if (i == 5) begin
        bus.d_req  = 1'b0;
        bus.if_req = 1'b0;
      end
    end
    @(negedge clk);

    // Random ack delays over both ports.
    for (int i = 0; i < 8; i++) begin
      dly    = $urandom_range(1, 8);
      isData = 1'($urandom_range(0, 1));
      we     = isData ? 1'($urandom_range(0, 1)) : 1'b0;
      addr   = {$urandom} & 32'hFFFF_FFFC;
      wdata  = $urandom;
      rdata  = $urandom;
      if (isData) applyStimulus(0, 0, 1, we, addr, wdata);
      else        applyStimulus(1, addr, 0, 0, 0, 0);
      serveMem("t6", isData, we, addr, wdata, rdata, dly, waited);
      bus.if_req = 1'b0;
      bus.d_req  = 1'b0;
    end

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", sb.size(), 0);
    checkOutput("ready_count", readyPulses, pushes);
    checkOutput("grant_count", grants, pushes + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
